// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle ramp sequencer feeding a free-running PWM counter; steps only on period boundaries.
// Optional abort input and logic enabled with `define PWM_RAMP_ABORT_EN.
module pwm_duty_ramp_ctrl #(
  parameter int RESOLUTION = 8,
  parameter int HOLD_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef PWM_RAMP_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  period_done,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [RESOLUTION-1:0] cmd_target,
  input  logic [RESOLUTION-1:0] cmd_step,
  input  logic [HOLD_W-1:0]     cmd_hold,
  output logic [RESOLUTION-1:0] dutyval,
  output logic                  busy,
  output logic                  ramp_done,
  output logic                  dbg_state
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t                state;
  logic [RESOLUTION-1:0] target_q;
  logic [RESOLUTION-1:0] step_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [HOLD_W-1:0]     period_cnt;

  logic                  going_up;
  logic [RESOLUTION:0]   distance;
  logic [RESOLUTION-1:0] next_duty;

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_valid seen in RAMP simply waits.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RAMP);
  assign dbg_state = state;

  // Distance computed one bit wider so neither direction can wrap or overshoot.
  always_comb begin
    going_up  = (target_q > dutyval);
    distance  = going_up ? ({1'b0, target_q} - {1'b0, dutyval})
                         : ({1'b0, dutyval} - {1'b0, target_q});
    next_duty = target_q;
    if (distance > {1'b0, step_q}) begin
      next_duty = going_up ? (dutyval + step_q) : (dutyval - step_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dutyval    <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      period_cnt <= '0;
      ramp_done  <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target_q   <= cmd_target;
            step_q     <= (cmd_step == '0) ? RESOLUTION'(1) : cmd_step;
            hold_q     <= cmd_hold;
            period_cnt <= '0;
            if (cmd_target != dutyval) begin
              state <= RAMP;
            end else begin
              ramp_done <= 1'b1;
            end
          end
        end
        RAMP: begin
`ifdef PWM_RAMP_ABORT_EN
          if (abort) begin
            state      <= IDLE;
            period_cnt <= '0;
          end else
`endif
          if (period_done) begin
            if (period_cnt == hold_q) begin
              period_cnt <= '0;
              dutyval    <= next_duty;
              if (next_duty == target_q) begin
                state     <= IDLE;
                ramp_done <= 1'b1;
              end
            end else begin
              period_cnt <= period_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
